msg_host: RTL

Synthesizable host-side end of the harness UART message link. Accepts a whole command message, serializes it word-by-word into a `uart_tx` instance, then optionally collects a fixed-length response packet from a `uart_rx` instance, with a response timeout. Used for on-chip loopback of the test harness and as the driver in board-level self-test builds.

---
 rtl/msg_host.sv | 135 +++++++++++++
 1 files changed

// File: rtl/msg_host.sv
// Host end of the harness UART message link: serializes a command message into
// a UART transmitter and optionally collects a fixed-length response packet.
module msg_host #(
  parameter int WORD_SIZE        = 8,
  parameter int WORDS_PER_PACKET = 4,
  parameter int TIMEOUT_CLKS     = 1_200_000
) (
  input  logic                                   clk,
  input  logic                                   n_reset,
  input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0]  cmd_msg,
  input  logic                                   cmd_valid,
  input  logic                                   expect_resp,
  output logic                                   cmd_ready,
  output logic [WORD_SIZE-1:0]                   tx_data,
  output logic                                   tx_start,
  input  logic                                   tx_ready,
  input  logic [WORD_SIZE-1:0]                   rx_data,
  input  logic                                   rx_valid,
  output logic [WORD_SIZE*WORDS_PER_PACKET-1:0]  resp_msg,
  output logic                                   resp_valid,
  output logic                                   timeout,
  output logic                                   busy,
  output logic [7:0]                             stray_count
);

  localparam int MSG_W = WORD_SIZE * WORDS_PER_PACKET;
  localparam int IDX_W = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam int CNT_W = $clog2(WORDS_PER_PACKET + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_PACKET - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_PACKET - 1);
  // Decision is taken on the edge where the counter would reach TIMEOUT_CLKS-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 2);

  typedef enum logic [1:0] {IDLE, SEND, GAP, RECV} state_t;

  state_t           state;
  logic [MSG_W-1:0] cmd_q;
  logic [MSG_W-1:0] shift_q;
  logic             exp_q;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] rx_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= IDLE;
      cmd_q       <= '0;
      shift_q     <= '0;
      exp_q       <= 1'b0;
      idx         <= '0;
      rx_cnt      <= '0;
      tmo_cnt     <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      resp_msg    <= '0;
      resp_valid  <= 1'b0;
      timeout     <= 1'b0;
      stray_count <= '0;
    end else begin
      tx_start   <= 1'b0;
      resp_valid <= 1'b0;
      timeout    <= 1'b0;

      // Words arriving outside RECV (including on the edge entering it) are dropped.
      if (rx_valid && state != RECV)
        stray_count <= sat_inc8(stray_count);

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd_msg;
            exp_q <= expect_resp;
            idx   <= '0;
            state <= SEND;
          end
        end

        SEND: begin
          if (tx_ready) begin
            // Shift the latched command so the next word is always at the top.
            tx_data  <= cmd_q[MSG_W-1 -: WORD_SIZE];
            cmd_q    <= {cmd_q[MSG_W-WORD_SIZE-1:0], {WORD_SIZE{1'b0}}};
            tx_start <= 1'b1;
            state    <= GAP;
          end
        end

        GAP: begin
          if (idx == LAST_IDX) begin
            if (exp_q) begin
              tmo_cnt <= '0;
              rx_cnt  <= '0;
              shift_q <= '0;
              state   <= RECV;
            end else begin
              state <= IDLE;
            end
          end else begin
            idx   <= idx + 1'b1;
            state <= SEND;
          end
        end

        RECV: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (rx_valid) begin
            shift_q <= {shift_q[MSG_W-WORD_SIZE-1:0], rx_data};
            rx_cnt  <= rx_cnt + 1'b1;
          end
          // A completing word beats a timeout on the same edge.
          if (rx_valid && rx_cnt == LAST_CNT) begin
            resp_msg   <= {shift_q[MSG_W-WORD_SIZE-1:0], rx_data};
            resp_valid <= 1'b1;
            state      <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
